// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch (IF) and load/store (LS) requesters.
// One transaction is outstanding at a time; each response is routed back to the requester that issued it.
module mem_arbiter #(
    parameter int bits = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [bits-1:0]   if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [bits-1:0]   if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [bits-1:0]   ls_addr,
    input  logic [bits-1:0]   ls_wdata,
    input  logic [bits/8-1:0] ls_be,
    output logic              ls_gnt,
    output logic              ls_valid,
    output logic [bits-1:0]   ls_rdata,
    output logic              proc_req,
    output logic              we,
    output logic [bits-1:0]   addr,
    output logic [bits-1:0]   wdata,
    output logic [bits/8-1:0] be,
    input  logic              mem_rdy,
    input  logic              valid,
    input  logic [bits-1:0]   rdata,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_drop;
    logic              r_we;
    logic [bits-1:0]   r_addr;
    logic [bits-1:0]   r_wdata;
    logic [bits/8-1:0] r_be;

    logic              w_idle;
    logic              w_if_win;
    logic              w_ls_win;
    logic              w_resp;
    logic              w_flush_hit;

    // Grants depend only on state and request lines, never on mem_rdy/valid.
    assign w_idle      = (r_state == S_IDLE) && rst;
    assign w_if_win    = w_idle && if_req && (!ls_req || (r_last == OWN_LS));
    assign w_ls_win    = w_idle && ls_req && (!if_req || (r_last == OWN_IF));
    assign w_resp      = (r_state == S_WAIT) && valid;
    assign w_flush_hit = if_flush && (r_owner == OWN_IF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_owner <= OWN_IF;
            r_last  <= OWN_LS;
            r_drop  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_if_win) begin
                        r_owner <= OWN_IF;
                        r_last  <= OWN_IF;
                        r_drop  <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= if_addr;
                        r_wdata <= '0;
                        r_be    <= '1;
                        r_state <= S_REQ;
                    end else if (w_ls_win) begin
                        r_owner <= OWN_LS;
                        r_last  <= OWN_LS;
                        r_drop  <= 1'b0;
                        r_we    <= ls_we;
                        r_addr  <= ls_addr;
                        r_wdata <= ls_wdata;
                        r_be    <= ls_be;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_rdy) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A flushed fetch still waits for its response so the memory side stays in step.
                    if (w_flush_hit) begin
                        r_drop <= 1'b1;
                    end
                    if (valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign if_gnt   = w_if_win;
    assign ls_gnt   = w_ls_win;
    assign if_valid = w_resp && (r_owner == OWN_IF) && !r_drop;
    assign ls_valid = w_resp && (r_owner == OWN_LS);
    assign if_rdata = if_valid ? rdata : '0;
    assign ls_rdata = ls_valid ? rdata : '0;

    assign proc_req = (r_state == S_REQ);
    assign we       = r_we;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign be       = r_be;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter that shares the single instruction/data memory port between the fetcher (IF side) and the load/store unit (LS side). Sits between both requesters and the memory model/controller, presents one `proc_req`/`mem_rdy`/`valid` handshake downstream, and routes each response to the requester that issued it. One transaction is outstanding at a time. On conflicting requests, the grant alternates round-robin between IF and LS.

## Interface
- `bits`, 32: address/data width; byte-enable width is `bits/8`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  bits  fetch address.
- `if_flush`  in  1  abandon the in-flight fetch (branch/redirect).
- `if_gnt`  out  1  fetch request accepted (1-cycle pulse).
- `if_valid`  out  1  fetch data valid (1-cycle pulse).
- `if_rdata`  out  bits  fetch data.
- `ls_req`  in  1  load/store request; held until `ls_gnt`.
- `ls_we`  in  1  1 = store, 0 = load.
- `ls_addr`  in  bits  load/store address.
- `ls_wdata`  in  bits  store data.
- `ls_be`  in  bits/8  store byte enables.
- `ls_gnt`  out  1  load/store request accepted (1-cycle pulse).
- `ls_valid`  out  1  load data valid, or store acknowledged (1-cycle pulse).
- `ls_rdata`  out  bits  load data.
- `proc_req`  out  1  request to memory.
- `we`  out  1  memory write enable.
- `addr`  out  bits  memory address.
- `wdata`  out  bits  memory write data.
- `be`  out  bits/8  memory byte enables.
- `mem_rdy`  in  1  memory accepts the request this cycle.
- `valid`  in  1  memory response valid.
- `rdata`  in  bits  memory read data.
- `busy`  out  1  transaction in progress (state is not IDLE).

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: `owner` (IF/LS), `last` (last granted), `drop` (discard response), latched `addr`/`wdata`/`be`/`we`.
- **IDLE:**
  - If exactly one request is present, grant it.
  - If both are present, grant the one that is not `last`.
  - Grant decode is combinational: `*_gnt`=1 in this cycle.
  - At the edge: latch the winner's fields (IF: `we`=0, `be`=all-ones, `wdata`=0), set `owner` and `last`, clear `drop`, go to REQ.
- **REQ:**
  - `proc_req`=1; `addr`/`we`/`wdata`/`be` driven from the latches.
  - At an edge with `mem_rdy`=1, go to WAIT; otherwise stay in REQ with all outputs held stable.
  - `valid` is ignored in REQ.
- **WAIT:**
  - `proc_req`=0.
  - On `valid`=1: drive `owner`'s `*_valid`=1 and `*_rdata`=`rdata` combinationally in the same cycle, then go to IDLE.
  - If `drop`=1, suppress `if_valid` but still return to IDLE.
- **Flush:**
  - `if_flush`=1 while `owner`=IF in REQ or WAIT sets `drop`.
  - The memory transaction still completes; its response is discarded.
  - `if_flush` in the IDLE grant cycle does not cancel that grant.
- The non-owner's `*_valid` is always 0; `*_rdata` reads 0 when its `*_valid`=0.
- `busy`=1 in REQ and WAIT.
- No combinational path from `mem_rdy` or `valid` to any `*_gnt`.

## Timing
- **Reset (`rst`=0, asynchronous):**
  - State: IDLE; `last`=LS, so IF wins the first conflict; `owner`=IF; `drop`=0.
  - Outputs: `proc_req`=0, `we`=0, `addr`=0, `wdata`=0, `be`=0, all `*_gnt`/`*_valid`=0, `busy`=0.
- **Reset mid-transaction:** the transaction is abandoned with no response pulse; memory-side cleanup is the memory model's responsibility.
- **Cycle sequence, zero memory wait:**
  - Cycle 0: request present → `*_gnt`.
  - Cycle 1: `proc_req` high with `mem_rdy`=1.
  - Cycle 2 (earliest): `valid` → `*_valid`.
  - Cycle 3: IDLE; next grant possible.
- Minimum 3 cycles per transaction; each `mem_rdy`-low cycle in REQ and each cycle without `valid` in WAIT adds one cycle.
- Any request arriving while `busy`=1 waits; its `*_gnt` fires in the first IDLE cycle.

## Test plan
- **Reset:** `rst`=0 mid-REQ → all outputs 0 immediately (asynchronous), state IDLE; after release, `if_req` with `if_addr`=0xBEEFBEEF → `if_gnt` in that cycle, `proc_req`=1 with `addr`=0xBEEFBEEF, `we`=0 in the next cycle.
- **Memory backpressure:** `mem_rdy`=0 for 3 cycles during an IF read → `proc_req`/`addr` held stable for 4 cycles; then `valid` with `rdata`=0xCAFECAFE → `if_valid`=1, `if_rdata`=0xCAFECAFE, `ls_valid`=0.
- **Simultaneous requests from reset:** `if_req` and `ls_req` both held continuously → grants alternate IF, LS, IF, LS; each `*_valid` goes only to the matching owner.
- **LS store:** `ls_we`=1, `ls_addr`=0x000000A1, `ls_wdata`=0xFAFAFAFA, `ls_be`=0x3 → memory side sees `we`=1, `be`=0x3, same address/data; `valid` → `ls_valid` pulse.
- **Flush:** `if_flush` pulsed in WAIT for an IF read → memory `valid` produces no `if_valid`; next IF request with `if_addr`=0x00000A1 is granted normally and returns data.
- **Back-to-back LS:** `ls_req` held continuously with `mem_rdy`=1 and 0-cycle `valid` → one `ls_gnt` every 3 cycles, `busy` low exactly one cycle between transactions.
